// File: rtl/framebuffer_stream_reader.sv
`default_nettype none
// ============================================================================
// Module      : framebuffer_stream_reader
// Description : Fetches a frame from word-addressed memory into a prefetch
//               FIFO and streams it out pixel by pixel, with optional 2x
//               pixel/line doubling.
// Revision    : 1.0 - initial release
// ============================================================================
module framebuffer_stream_reader #(
  parameter int DATA_WIDTH    = 16,
  parameter int ADDR_WIDTH    = 24,
  parameter int FB_WIDTH      = 32,
  parameter int FB_HEIGHT     = 32,
  parameter int FIFO_DEPTH    = 16,
  parameter int PRELOAD_LEVEL = FIFO_DEPTH
) (
  input  logic                  clk,
  input  logic                  reset_n_i,
  input  logic                  start_frame_i,
  input  logic [ADDR_WIDTH-1:0] base_address_i,
  input  logic                  scale2x_i,
  input  logic                  stream_ena_i,
  output logic [DATA_WIDTH-1:0] stream_data_o,
  output logic                  stream_preloading_o,
  output logic                  stream_err_underflow_o,
  output logic                  frame_done_o,
  output logic                  mem_sel_o,
  output logic [ADDR_WIDTH-1:0] mem_address_o,
  input  logic                  mem_ack_i,
  input  logic [DATA_WIDTH-1:0] mem_data_i
);

  localparam int c_PW   = $clog2(FIFO_DEPTH);
  localparam int c_CW   = c_PW + 1;
  localparam int c_XW   = (FB_WIDTH > 1) ? $clog2(FB_WIDTH) : 1;
  localparam int c_YW   = (FB_HEIGHT > 1) ? $clog2(FB_HEIGHT) : 1;
  localparam int c_NPIX = FB_WIDTH * FB_HEIGHT;
  localparam int c_NW   = $clog2(4 * c_NPIX + 1);
  localparam logic [c_NW-1:0]       c_LAST_1X = c_NW'(c_NPIX - 1);
  localparam logic [c_NW-1:0]       c_LAST_2X = c_NW'(4 * c_NPIX - 1);
  localparam logic [c_XW-1:0]       c_X_LAST  = c_XW'(FB_WIDTH - 1);
  localparam logic [c_YW-1:0]       c_Y_LAST  = c_YW'(FB_HEIGHT - 1);
  localparam logic [c_CW-1:0]       c_DEPTH   = c_CW'(FIFO_DEPTH);
  localparam logic [c_CW-1:0]       c_LEVEL   = c_CW'(PRELOAD_LEVEL);
  localparam logic [ADDR_WIDTH-1:0] c_LINE    = ADDR_WIDTH'(FB_WIDTH);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_PRELOAD = 2'd1,
    S_STREAM  = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  // Prefetch FIFO
  logic [DATA_WIDTH-1:0] r_fifo [FIFO_DEPTH];
  logic [c_PW-1:0]       r_wr_ptr;
  logic [c_PW-1:0]       r_rd_ptr;
  logic [c_CW-1:0]       r_count;

  // Fetcher
  logic                  r_mem_sel;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic                  r_discard;     // in-flight request belongs to an abandoned frame
  logic [ADDR_WIDTH-1:0] r_line_base;   // address of pixel 0 of the line being fetched
  logic [c_XW-1:0]       r_fx;
  logic [c_YW-1:0]       r_fy;
  logic                  r_rep;         // second fetch of the same line (scale2x)
  logic                  r_issue_done;
  logic                  r_scale;

  // Stream side
  logic [c_NW-1:0]       r_pix;
  logic                  r_half;        // first of the two presentations of a pixel done
  logic                  r_underflow;
  logic                  r_frame_done;

  logic w_empty, w_in_stream, w_take, w_pop, w_ack, w_push, w_issue;
  logic w_all_fetched, w_last;
  logic [ADDR_WIDTH-1:0] w_fetch_addr;

  assign w_empty       = (r_count == '0);
  assign w_in_stream   = (r_state == S_STREAM);
  assign w_take        = w_in_stream && stream_ena_i && !w_empty && !start_frame_i;
  assign w_pop         = w_take && (!r_scale || r_half);
  assign w_ack         = r_mem_sel && mem_ack_i;
  assign w_push        = w_ack && !r_discard && !start_frame_i;
  assign w_issue       = !r_mem_sel && (r_state != S_IDLE) && !r_issue_done &&
                         (r_count < c_DEPTH) && !start_frame_i;
  assign w_all_fetched = r_issue_done && !r_mem_sel;
  assign w_last        = w_take && (r_pix == (r_scale ? c_LAST_2X : c_LAST_1X));
  assign w_fetch_addr  = r_line_base + ADDR_WIDTH'(r_fx);

  // State register
  always_ff @(posedge clk) begin
    if (!reset_n_i) r_state <= S_IDLE;
    else            r_state <= w_state_nxt;
  end

  // Next-state decode and stream-side outputs
  always_comb begin
    w_state_nxt         = r_state;
    stream_preloading_o = 1'b0;
    stream_data_o       = '0;
    if (r_state == S_PRELOAD) stream_preloading_o = 1'b1;
    if (w_in_stream && !w_empty) stream_data_o = r_fifo[r_rd_ptr];
    if (start_frame_i) begin
      w_state_nxt = S_PRELOAD;
    end else begin
      case (r_state)
        S_PRELOAD: if ((r_count >= c_LEVEL) || w_all_fetched) w_state_nxt = S_STREAM;
        S_STREAM:  if (w_last) w_state_nxt = S_IDLE;
        default:   w_state_nxt = r_state;
      endcase
    end
  end

  // Memory fetcher: one outstanding request, raster order, optional line repeat
  always_ff @(posedge clk) begin
    if (!reset_n_i) begin
      r_mem_sel    <= 1'b0;
      r_mem_addr   <= '0;
      r_discard    <= 1'b0;
      r_line_base  <= '0;
      r_fx         <= '0;
      r_fy         <= '0;
      r_rep        <= 1'b0;
      r_issue_done <= 1'b0;
      r_scale      <= 1'b0;
    end else begin
      if (w_ack) begin
        r_mem_sel <= 1'b0;
        r_discard <= 1'b0;
      end
      if (start_frame_i) begin
        // A request still waiting for its ack stays on the bus; its data is dropped.
        r_discard    <= r_mem_sel && !mem_ack_i;
        r_line_base  <= base_address_i;
        r_fx         <= '0;
        r_fy         <= '0;
        r_rep        <= 1'b0;
        r_issue_done <= 1'b0;
        r_scale      <= scale2x_i;
      end else if (w_issue) begin
        r_mem_sel  <= 1'b1;
        r_mem_addr <= w_fetch_addr;
        if (r_fx == c_X_LAST) begin
          r_fx <= '0;
          if (r_scale && !r_rep) begin
            r_rep <= 1'b1;
          end else begin
            r_rep       <= 1'b0;
            r_line_base <= r_line_base + c_LINE;
            if (r_fy == c_Y_LAST) r_issue_done <= 1'b1;
            else                  r_fy         <= r_fy + 1'b1;
          end
        end else begin
          r_fx <= r_fx + 1'b1;
        end
      end
    end
  end

  // FIFO storage write
  always_ff @(posedge clk) begin
    if (w_push) r_fifo[r_wr_ptr] <= mem_data_i;
  end

  // FIFO pointers and fill count; flushed by reset or a new frame
  always_ff @(posedge clk) begin
    if (!reset_n_i || start_frame_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (!w_push && w_pop) r_count <= r_count - 1'b1;
    end
  end

  // Consumed-pixel count, doubling phase, underflow and frame-done pulse
  always_ff @(posedge clk) begin
    if (!reset_n_i) begin
      r_pix        <= '0;
      r_half       <= 1'b0;
      r_underflow  <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= w_last;
      if (start_frame_i) begin
        r_pix       <= '0;
        r_half      <= 1'b0;
        r_underflow <= 1'b0;
      end else begin
        if (w_take) begin
          r_pix <= r_pix + 1'b1;
          if (r_scale) r_half <= !r_half;
        end
        if (w_in_stream && stream_ena_i && w_empty) r_underflow <= 1'b1;
      end
    end
  end

  assign stream_err_underflow_o = r_underflow;
  assign frame_done_o           = r_frame_done;
  assign mem_sel_o              = r_mem_sel;
  assign mem_address_o          = r_mem_addr;

endmodule
`default_nettype wire

// File: tb/tb_framebuffer_stream_reader.sv
`default_nettype none
// ============================================================================
// Module      : tb_framebuffer_stream_reader
// Description : Scoreboard bench for framebuffer_stream_reader (4x4 frame,
//               8-entry FIFO, memory returns address[15:0] two cycles later).
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_framebuffer_stream_reader;

  logic        clk = 1'b0;
  logic        reset_n_i = 1'b0;
  logic        start_frame_i = 1'b0;
  logic [23:0] base_address_i = '0;
  logic        scale2x_i = 1'b0;
  logic        stream_ena_i = 1'b0;
  logic [15:0] stream_data_o;
  logic        stream_preloading_o;
  logic        stream_err_underflow_o;
  logic        frame_done_o;
  logic        mem_sel_o;
  logic [23:0] mem_address_o;
  logic        mem_ack_i = 1'b0;
  logic [15:0] mem_data_i = '0;

  framebuffer_stream_reader #(
    .DATA_WIDTH(16), .ADDR_WIDTH(24), .FB_WIDTH(4), .FB_HEIGHT(4), .FIFO_DEPTH(8)
  ) dut (
    .clk(clk), .reset_n_i(reset_n_i), .start_frame_i(start_frame_i),
    .base_address_i(base_address_i), .scale2x_i(scale2x_i), .stream_ena_i(stream_ena_i),
    .stream_data_o(stream_data_o), .stream_preloading_o(stream_preloading_o),
    .stream_err_underflow_o(stream_err_underflow_o), .frame_done_o(frame_done_o),
    .mem_sel_o(mem_sel_o), .mem_address_o(mem_address_o),
    .mem_ack_i(mem_ack_i), .mem_data_i(mem_data_i)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int done_cnt = 0;
  int ack_total = 0;
  int wcnt = 0;
  bit prev_done = 1'b0;
  bit skip_ack = 1'b0;
  bit watch_new = 1'b0;
  int stale_ack_cyc = -1;
  logic [23:0] stale_addr = '0;
  int first_new_cyc = -1;
  logic [15:0] q_exp[$];   // expected stream pixels
  logic [23:0] q_req[$];   // expected request addresses
  logic [15:0] mon_e;
  logic [23:0] bus_a;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(posedge clk) cyc++;

  // Memory model and request scoreboard
  always @(negedge clk) begin
    if (!reset_n_i) begin
      mem_ack_i = 1'b0;
      wcnt = 0;
    end else begin
      if (watch_new && mem_sel_o && mem_address_o == 24'h000500) begin
        first_new_cyc = cyc;
        watch_new = 1'b0;
      end
      if (mem_ack_i) begin
        mem_ack_i = 1'b0;
      end else if (mem_sel_o) begin
        wcnt++;
        if (wcnt == 2) begin
          wcnt = 0;
          mem_ack_i = 1'b1;
          mem_data_i = mem_address_o[15:0];
          ack_total++;
          if (skip_ack) begin
            skip_ack = 1'b0;
            stale_ack_cyc = cyc;
            stale_addr = mem_address_o;
          end else if (q_req.size() == 0) begin
            fail("unexpected_request");
          end else begin
            bus_a = q_req.pop_front();
            check("req_addr", {8'h0, mem_address_o}, {8'h0, bus_a});
          end
        end
      end else begin
        wcnt = 0;
      end
    end
  end

  // Stream monitor: pops an expected pixel whenever a pixel is taken
  always @(negedge clk) begin
    if (reset_n_i) begin
      if (stream_ena_i && stream_preloading_o) begin
        check("preload_data_zero", {16'h0, stream_data_o}, 32'h0);
      end else if (stream_ena_i && stream_data_o != 16'h0) begin
        if (q_exp.size() == 0) begin
          fail("unexpected_pixel");
        end else begin
          mon_e = q_exp.pop_front();
          check("pixel", {16'h0, stream_data_o}, {16'h0, mon_e});
        end
      end
      if (frame_done_o) begin
        done_cnt++;
        check("done_all_consumed", q_exp.size(), 0);
        if (prev_done) fail("frame_done_wider_than_one_cycle");
      end
      prev_done = frame_done_o;
    end else begin
      prev_done = 1'b0;
    end
  end

  // Model of the frame: raster order, line and pixel doubled when scaling
  task automatic start(input logic [23:0] base, input bit sc);
    logic [23:0] a;
    int reps;
    reps = sc ? 2 : 1;
    stream_ena_i = 1'b0;
    q_exp.delete();
    q_req.delete();
    skip_ack = mem_sel_o;
    for (int y = 0; y < 4; y++)
      for (int r = 0; r < reps; r++)
        for (int x = 0; x < 4; x++) begin
          a = base + 24'(y * 4 + x);
          q_req.push_back(a);
          for (int h = 0; h < reps; h++) q_exp.push_back(a[15:0]);
        end
    base_address_i = base;
    scale2x_i = sc;
    start_frame_i = 1'b1;
    tick();
    start_frame_i = 1'b0;
  endtask

  task automatic wait_preload_end();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 300 && !ok; i++) begin
      if (!stream_preloading_o) ok = 1'b1;
      else tick();
    end
    if (!ok) fail("preload_timeout");
  endtask

  // kind 0: ena every p-th cycle, 1: ena held, 2: random with density 1/p
  task automatic run_frame(input int kind, input int p);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 3000 && !done; i++) begin
      case (kind)
        0:       stream_ena_i = ((i % p) == (p - 1));
        1:       stream_ena_i = 1'b1;
        default: stream_ena_i = ($urandom_range(0, p - 1) == 0);
      endcase
      tick();
      if (frame_done_o) done = 1'b1;
    end
    stream_ena_i = 1'b0;
    if (!done) fail("frame_done_timeout");
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_data"}, {16'h0, stream_data_o}, 32'h0);
    check({name, "_preloading"}, {31'h0, stream_preloading_o}, 32'h0);
    check({name, "_underflow"}, {31'h0, stream_err_underflow_o}, 32'h0);
    check({name, "_frame_done"}, {31'h0, frame_done_o}, 32'h0);
    check({name, "_mem_sel"}, {31'h0, mem_sel_o}, 32'h0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout");
    $fatal(1, "simulation time limit");
  end

  initial begin
    int d0, a0, p;
    bit sel_seen;
    logic [23:0] rb;
    bit rs;

    // Reset state
    tick(); tick();
    check_all_zero("reset");
    reset_n_i = 1'b1;
    tick();

    // Reset asserted mid-frame
    start(24'h000100, 1'b0);
    for (int i = 0; i < 30; i++) begin
      stream_ena_i = $urandom_range(0, 1) == 1;
      tick();
    end
    stream_ena_i = 1'b0;
    reset_n_i = 1'b0;
    tick();
    check_all_zero("midreset");
    tick();
    reset_n_i = 1'b1;
    q_exp.delete();
    q_req.delete();
    skip_ack = 1'b0;
    sel_seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      sel_seen |= mem_sel_o;
    end
    check("no_request_after_reset", {31'h0, sel_seen}, 32'h0);

    // Preload with ena low, then ena every 4th cycle
    a0 = ack_total;
    start(24'h000100, 1'b0);
    wait_preload_end();
    check("acks_at_preload_end", ack_total - a0, 8);
    check("requests_left", q_req.size(), 8);
    sel_seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      sel_seen |= mem_sel_o;
    end
    check("no_request_while_full", {31'h0, sel_seen}, 32'h0);
    d0 = done_cnt;
    run_frame(0, 4);
    tick();
    check("done_pulses_1x", done_cnt - d0, 1);
    check("underflow_slow_ena", {31'h0, stream_err_underflow_o}, 32'h0);
    check("frame_done_low_after", {31'h0, frame_done_o}, 32'h0);
    check("idle_not_preloading", {31'h0, stream_preloading_o}, 32'h0);
    check("idle_no_request", {31'h0, mem_sel_o}, 32'h0);
    stream_ena_i = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    stream_ena_i = 1'b0;

    // Ena held high from stream entry: underflow expected and sticky
    start(24'h000200, 1'b0);
    wait_preload_end();
    check("underflow_clear_at_stream", {31'h0, stream_err_underflow_o}, 32'h0);
    d0 = done_cnt;
    run_frame(1, 1);
    check("underflow_set", {31'h0, stream_err_underflow_o}, 32'h1);
    for (int i = 0; i < 5; i++) tick();
    check("underflow_sticky", {31'h0, stream_err_underflow_o}, 32'h1);
    check("done_pulses_held", done_cnt - d0, 1);

    // New frame while a request is in flight
    start(24'h000100, 1'b0);
    check("underflow_cleared_by_start", {31'h0, stream_err_underflow_o}, 32'h0);
    sel_seen = 1'b0;
    for (int i = 0; i < 100 && !sel_seen; i++) begin
      if (mem_sel_o && mem_address_o == 24'h000103) sel_seen = 1'b1;
      else tick();
    end
    check("saw_request_103", {31'h0, sel_seen}, 32'h1);
    stale_ack_cyc = -1;
    first_new_cyc = -1;
    watch_new = 1'b1;
    start(24'h000500, 1'b0);
    check("sel_held_over_start", {31'h0, mem_sel_o}, 32'h1);
    check("addr_held_over_start", {8'h0, mem_address_o}, 32'h000103);
    d0 = done_cnt;
    run_frame(0, 4);
    tick();
    check("done_pulses_restart", done_cnt - d0, 1);
    check("stale_addr", {8'h0, stale_addr}, 32'h000103);
    check("new_req_after_stale_ack", {31'h0, (stale_ack_cyc >= 0) && (first_new_cyc > stale_ack_cyc)}, 32'h1);
    check("underflow_restart", {31'h0, stream_err_underflow_o}, 32'h0);
    watch_new = 1'b0;

    // Scale2x frame
    start(24'h000300, 1'b1);
    d0 = done_cnt;
    run_frame(2, 2);
    tick();
    check("done_pulses_2x", done_cnt - d0, 1);
    check("requests_left_2x", q_req.size(), 0);

    // Randomised frames
    for (int f = 0; f < 4; f++) begin
      rb = {8'($urandom), 16'($urandom_range(16'h0100, 16'hFF00))};
      rs = $urandom_range(0, 1) == 1;
      p  = $urandom_range(1, 4);
      start(rb, rs);
      d0 = done_cnt;
      run_frame(2, p);
      tick();
      check("done_pulses_rand", done_cnt - d0, 1);
      check("requests_left_rand", q_req.size(), 0);
      check("pixels_left_rand", q_exp.size(), 0);
    end

    tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/framebuffer_stream_reader.md
FRAMEBUFFER_STREAM_READER -- requirements
Module: framebuffer_stream_reader

Interface
REQ-001 Parameter DATA_WIDTH, default 16, pixel/word width in bits.
REQ-002 Parameter ADDR_WIDTH, default 24, memory word-address width.
REQ-003 Parameter FB_WIDTH, default 32, source pixels per line.
REQ-004 Parameter FB_HEIGHT, default 32, source lines per frame.
REQ-005 Parameter FIFO_DEPTH, default 16, prefetch FIFO entries; power of two, >=4.
REQ-006 Parameter PRELOAD_LEVEL, default FIFO_DEPTH, FIFO fill count that ends preloading; 1..FIFO_DEPTH.
REQ-007 clk  input  1  single clock; all logic on its rising edge.
REQ-008 reset_n_i  input  1  one clock; reset is synchronous and active-low.
REQ-009 start_frame_i  input  1  one-cycle pulse; restart frame fetch and stream.
REQ-010 base_address_i  input  ADDR_WIDTH  frame base word address, sampled on start_frame_i.
REQ-011 scale2x_i  input  1  pixel/line doubling enable, sampled on start_frame_i.
REQ-012 stream_ena_i  input  1  consumer takes one pixel this cycle.
REQ-013 stream_data_o  output  DATA_WIDTH  current pixel.
REQ-014 stream_preloading_o  output  1  high while in PRELOAD.
REQ-015 stream_err_underflow_o  output  1  sticky underflow flag.
REQ-016 frame_done_o  output  1  one-cycle pulse after last pixel consumed.
REQ-017 mem_sel_o  output  1  read request, held until mem_ack_i.
REQ-018 mem_address_o  output  ADDR_WIDTH  request word address, stable while mem_sel_o high.
REQ-019 mem_ack_i  input  1  one-cycle pulse; mem_data_i valid same cycle.
REQ-020 mem_data_i  input  DATA_WIDTH  read data.

Function
REQ-021 Stream FSM SHALL have states IDLE, PRELOAD, STREAM; start_frame_i in any state -> PRELOAD next cycle.
REQ-022 start_frame_i SHALL flush FIFO, zero x/y/pixel counters, clear underflow, load fetch address = base_address_i.
REQ-023 Fetcher SHALL keep at most one request outstanding; issue only when FIFO count + 1 <= FIFO_DEPTH, frame fetch incomplete, FSM not IDLE.
REQ-024 Fetch order SHALL be base + y*FB_WIDTH + x, x fastest; address arithmetic modulo 2^ADDR_WIDTH.
REQ-025 scale2x=1: each source line SHALL be fetched twice consecutively (2*FB_HEIGHT line fetches); scale2x=0: each once.
REQ-026 start_frame_i with request in flight: mem_sel_o SHALL stay high until mem_ack_i, that data discarded, new frame's first request issued no earlier than cycle after that ack.
REQ-027 PRELOAD -> STREAM when FIFO count >= PRELOAD_LEVEL or all frame words fetched; stream_ena_i ignored in PRELOAD, no underflow there.
REQ-028 STREAM: stream_data_o SHALL equal FIFO head when non-empty, else 0; in IDLE/PRELOAD 0.
REQ-029 scale2x=0: each stream_ena_i cycle in STREAM pops one entry; scale2x=1: entry popped on every second ena cycle (each pixel presented for two ena cycles).
REQ-030 stream_ena_i in STREAM with FIFO empty SHALL set stream_err_underflow_o next cycle and consume no pixel count.
REQ-031 Simultaneous push and pop SHALL leave count unchanged; push to full FIFO SHALL never occur (REQ-023).
REQ-032 After FB_WIDTH*FB_HEIGHT output pixels (x4 when scale2x) consumed: frame_done_o pulses one cycle, FSM -> IDLE; start_frame_i same cycle wins.

Reset
REQ-033 reset_n_i low at a clock edge SHALL force IDLE, FIFO empty, counters 0, all outputs 0 (mem_sel_o abandoned; bus model must tolerate), overriding every other input.

Verification
REQ-034 Bench (FB 4x4, FIFO_DEPTH 8, memory returns data = address[15:0], ack 2 cycles after sel) SHALL cover:
- Reset low 2 cycles mid-frame -> all outputs 0, mem_sel_o 0 next cycle, no further requests.
- start_frame base 0x000100, ena low -> requests 0x100..0x107, preloading falls after 8th ack, mem_sel_o stays 0 until a pop.
- Then ena every 4th cycle -> data 0x100..0x10F in order, underflow 0, frame_done one pulse after 16th pixel, FSM IDLE.
- Ena held high from STREAM entry -> underflow set once FIFO empties, stays 1 until next start_frame.
- scale2x=1 -> output 0x100,0x100,0x101,0x101..0x103,0x103 twice, then row 0x104; 64 pixels then frame_done.
- start_frame while request to 0x103 in flight -> its ack data not output; first new request at new base; underflow cleared.
